// File: rtl/wb_pkg.sv
// Shared types and load-type encodings for the register-file writeback path.
package wb_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef logic [4:0] reg_addr_t;

    typedef struct packed {
        reg_addr_t   rd;
        logic [2:0]  funct3;
        logic [1:0]  byte_off;
        logic [31:0] word;
    } ld_entry_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Small circular FIFO holding raw load responses until the writeback port is free.
module wb_load_fifo
    import wb_pkg::*;
#(
    parameter int LD_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  ld_entry_t                      push_data,
    input  logic                           pop,
    output ld_entry_t                      pop_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(LD_DEPTH+1)-1:0]  count
);

    localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
    localparam int CW = $clog2(LD_DEPTH + 1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(LD_DEPTH);

    ld_entry_t       mem_r [LD_DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            push_s;
    logic            pop_s;

    assign full     = (count_r == CNT_DEPTH);
    assign empty    = (count_r == '0);
    assign count    = count_r;
    assign pop_data = mem_r[rd_ptr_r];
    assign push_s   = push && !full;
    assign pop_s    = pop && !empty;

    // Storage array; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LD_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Merges ALU results and buffered load responses onto the register-file write port,
// with ALU priority bounded by a starvation counter.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int LD_DEPTH   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_byte_off,
    input  logic [31:0] ld_word,
    output logic        w_en,
    output logic [4:0]  rd,
    output logic [31:0] rdData
);

    localparam int CW = $clog2(LD_DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_DEPTH  = CW'(LD_DEPTH);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    function automatic logic [31:0] load_extend(input ld_entry_t e);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = e.word[{e.byte_off, 3'b000} +: 8];
        h = e.word[{e.byte_off[1], 4'b0000} +: 16];
        case (e.funct3)
            F3_LB:   r = {{24{b[7]}}, b};
            F3_LH:   r = {{16{h[15]}}, h};
            F3_LW:   r = e.word;
            F3_LBU:  r = {24'h00_0000, b};
            F3_LHU:  r = {16'h0000, h};
            default: r = e.word;
        endcase
        return r;
    endfunction

    ld_entry_t       ld_in_s;
    ld_entry_t       head_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [CW-1:0]   fifo_count_s;
    logic [CW-1:0]   count_nxt_s;
    logic            push_s;
    logic            pop_s;
    logic            alu_win_s;
    logic            alu_stall_s;
    logic [SW-1:0]   starve_cnt_r;
    logic [SW-1:0]   starve_nxt_s;
    logic            ld_ready_r;
    logic            w_en_r;
    reg_addr_t       rd_r;
    logic [31:0]     rd_data_r;
    logic            w_en_nxt_s;
    reg_addr_t       rd_nxt_s;
    logic [31:0]     data_nxt_s;

    assign ld_in_s     = '{rd: ld_rd, funct3: ld_funct3, byte_off: ld_byte_off, word: ld_word};
    assign push_s      = ld_valid && ld_ready_r && !fifo_full_s;
    assign alu_stall_s = (starve_cnt_r == STARVE_LIM) && !fifo_empty_s;

    assign alu_stall = alu_stall_s;
    assign ld_ready  = ld_ready_r;
    assign w_en      = w_en_r;
    assign rd        = rd_r;
    assign rdData    = rd_data_r;

    wb_load_fifo #(
        .LD_DEPTH (LD_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (ld_in_s),
        .pop       (pop_s),
        .pop_data  (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Source select: ALU first, then FIFO head, else idle.
    always_comb begin
        alu_win_s  = 1'b0;
        pop_s      = 1'b0;
        w_en_nxt_s = 1'b0;
        rd_nxt_s   = rd_r;
        data_nxt_s = rd_data_r;
        if (alu_valid && !alu_stall_s) begin
            alu_win_s  = 1'b1;
            w_en_nxt_s = (alu_rd != 5'd0);
            rd_nxt_s   = alu_rd;
            data_nxt_s = alu_data;
        end else if (!fifo_empty_s) begin
            pop_s      = 1'b1;
            w_en_nxt_s = (head_s.rd != 5'd0);
            rd_nxt_s   = head_s.rd;
            data_nxt_s = load_extend(head_s);
        end else begin
            w_en_nxt_s = 1'b0;
        end
    end

    // Starvation counter and next FIFO occupancy (ready is registered from it).
    always_comb begin
        starve_nxt_s = starve_cnt_r;
        count_nxt_s  = fifo_count_s;
        if (fifo_empty_s || pop_s) begin
            starve_nxt_s = '0;
        end else if (alu_win_s && (starve_cnt_r != STARVE_LIM)) begin
            starve_nxt_s = starve_cnt_r + STARVE_ONE;
        end else begin
            starve_nxt_s = starve_cnt_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = fifo_count_s + CNT_ONE;
            2'b01:   count_nxt_s = fifo_count_s - CNT_ONE;
            default: count_nxt_s = fifo_count_s;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= '0;
            ld_ready_r   <= 1'b0;
        end else begin
            starve_cnt_r <= starve_nxt_s;
            ld_ready_r   <= (count_nxt_s < CNT_DEPTH);
        end
    end

    // Registered write port; rd/data hold through idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_en_r    <= 1'b0;
            rd_r      <= 5'd0;
            rd_data_r <= 32'h0000_0000;
        end else begin
            w_en_r    <= w_en_nxt_s;
            rd_r      <= rd_nxt_s;
            rd_data_r <= data_nxt_s;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed vector bench for writeback_unit: extension table plus multi-cycle sequences.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_byte_off;
    logic [31:0] ld_word;
    logic        w_en;
    logic [4:0]  rd;
    logic [31:0] rdData;

    int n_cmp = 0;
    int n_err = 0;

    writeback_unit #(.LD_DEPTH(2), .STARVE_MAX(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_stall   (alu_stall),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_rd       (ld_rd),
        .ld_funct3   (ld_funct3),
        .ld_byte_off (ld_byte_off),
        .ld_word     (ld_word),
        .w_en        (w_en),
        .rd          (rd),
        .rdData      (rdData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_ld;
        logic [4:0]  dst;
        logic [31:0] val;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic        exp_wen;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid   = 1'b0;
        alu_rd      = 5'd0;
        alu_data    = 32'h0;
        ld_valid    = 1'b0;
        ld_rd       = 5'd0;
        ld_funct3   = 3'b010;
        ld_byte_off = 2'd0;
        ld_word     = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc;
        int          alu_issued;
        int          alu_seen;
        bit          alu_ok;
        bit          full_checked;
        logic        rdy;
        logic        stl;
        logic [4:0]  got [$];

        vecs[0]  = '{1'b0, 5'd5,  32'h0000_1234, 3'b000, 2'd0, 1'b1, 32'h0000_1234};
        vecs[1]  = '{1'b0, 5'd0,  32'hAAAA_5555, 3'b000, 2'd0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 5'd31, 32'hDEAD_BEEF, 3'b000, 2'd0, 1'b1, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b1, 5'd7,  32'h80FF_FF7F, 3'b000, 2'd3, 1'b1, 32'hFFFF_FF80};
        vecs[4]  = '{1'b1, 5'd7,  32'h80FF_FF7F, 3'b100, 2'd3, 1'b1, 32'h0000_0080};
        vecs[5]  = '{1'b1, 5'd8,  32'h80FF_FF7F, 3'b001, 2'd2, 1'b1, 32'hFFFF_80FF};
        vecs[6]  = '{1'b1, 5'd8,  32'h80FF_FF7F, 3'b101, 2'd2, 1'b1, 32'h0000_80FF};
        vecs[7]  = '{1'b1, 5'd9,  32'h80FF_FF7F, 3'b010, 2'd1, 1'b1, 32'h80FF_FF7F};
        vecs[8]  = '{1'b1, 5'd9,  32'h80FF_FF7F, 3'b000, 2'd0, 1'b1, 32'h0000_007F};
        vecs[9]  = '{1'b1, 5'd10, 32'h80FF_FF7F, 3'b001, 2'd3, 1'b1, 32'hFFFF_80FF};
        vecs[10] = '{1'b1, 5'd11, 32'h1234_8765, 3'b011, 2'd1, 1'b1, 32'h1234_8765};
        vecs[11] = '{1'b1, 5'd0,  32'h1234_8765, 3'b010, 2'd0, 1'b0, 32'h0};

        // Reset state
        idle_inputs();
        rst_n = 1'b0;
        #2;
        chk("rst_wen",   32'(w_en), 32'd0);
        chk("rst_rd",    32'(rd), 32'd0);
        chk("rst_data",  rdData, 32'h0);
        chk("rst_ready", 32'(ld_ready), 32'd0);
        chk("rst_stall", 32'(alu_stall), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(ld_ready), 32'd1);

        // Table: single ALU results and single loads
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_ld) begin
                ld_valid    = 1'b1;
                ld_rd       = vecs[i].dst;
                ld_word     = vecs[i].val;
                ld_funct3   = vecs[i].f3;
                ld_byte_off = vecs[i].off;
            end else begin
                alu_valid = 1'b1;
                alu_rd    = vecs[i].dst;
                alu_data  = vecs[i].val;
            end
            step();
            idle_inputs();
            if (!vecs[i].is_ld) begin
                chk($sformatf("vec%0d_wen", i), 32'(w_en), 32'(vecs[i].exp_wen));
                if (vecs[i].exp_wen) begin
                    chk($sformatf("vec%0d_rd", i), 32'(rd), 32'(vecs[i].dst));
                    chk($sformatf("vec%0d_data", i), rdData, vecs[i].exp_data);
                end
            end
            step();
            if (vecs[i].is_ld) begin
                chk($sformatf("vec%0d_wen", i), 32'(w_en), 32'(vecs[i].exp_wen));
                if (vecs[i].exp_wen) begin
                    chk($sformatf("vec%0d_rd", i), 32'(rd), 32'(vecs[i].dst));
                    chk($sformatf("vec%0d_data", i), rdData, vecs[i].exp_data);
                end
            end
        end
        step();
        chk("idle_wen", 32'(w_en), 32'd0);

        // FIFO full under continuous ALU traffic: three loads, none lost or duplicated
        acc = 0; alu_issued = 0; alu_seen = 0; alu_ok = 1'b1; full_checked = 1'b0;
        for (int c = 0; c <= 46; c++) begin
            if (c > 0) begin
                if (w_en && rd == 5'd20) begin
                    if (rdData != 32'h1000 + 32'(alu_seen)) alu_ok = 1'b0;
                    alu_seen++;
                end else if (w_en) begin
                    got.push_back(rd);
                end
            end
            if (c == 46) break;
            rdy = ld_ready;
            stl = alu_stall;
            if (acc == 2 && !full_checked) begin
                chk("full_ready_low", 32'(ld_ready), 32'd0);
                full_checked = 1'b1;
            end
            alu_valid   = (c < 40);
            alu_rd      = 5'd20;
            alu_data    = 32'h1000 + 32'(alu_issued);
            ld_valid    = (acc < 3);
            ld_rd       = 5'(acc + 1);
            ld_funct3   = 3'b010;
            ld_byte_off = 2'd0;
            ld_word     = 32'hC0DE_0000 + 32'(acc);
            if (ld_valid && rdy) acc++;
            if (alu_valid && !stl) alu_issued++;
            step();
        end
        idle_inputs();
        chk("full_accepts", 32'(acc), 32'd3);
        chk("full_ld_writes", 32'(got.size()), 32'd3);
        for (int k = 0; k < 3 && k < got.size(); k++) begin
            chk($sformatf("full_order%0d", k), 32'(got[k]), 32'(k + 1));
        end
        chk("full_alu_seq_ok", 32'(alu_ok), 32'd1);
        chk("full_alu_count", 32'(alu_seen), 32'(alu_issued));

        // Starvation: one buffered load, ALU every cycle
        alu_issued = 0;
        for (int c = 0; c <= 6; c++) begin
            chk($sformatf("starve_stall_c%0d", c), 32'(alu_stall), 32'(c == 5));
            stl         = alu_stall;
            alu_valid   = 1'b1;
            alu_rd      = 5'd11;
            alu_data    = 32'd100 + 32'(alu_issued);
            ld_valid    = (c == 0);
            ld_rd       = 5'd9;
            ld_funct3   = 3'b010;
            ld_word     = 32'h0000_0055;
            if (!stl) alu_issued++;
            step();
            chk($sformatf("starve_wen_c%0d", c), 32'(w_en), 32'd1);
            chk($sformatf("starve_rd_c%0d", c), 32'(rd), (c == 5) ? 32'd9 : 32'd11);
            chk($sformatf("starve_data_c%0d", c), rdData,
                (c == 5) ? 32'h55 : ((c < 5) ? 32'd100 + 32'(c) : 32'd100 + 32'(c - 1)));
        end
        idle_inputs();
        step();

        // Ordering: back-to-back loads with ALU idle
        for (int c = 0; c <= 4; c++) begin
            ld_valid  = (c < 3);
            ld_rd     = 5'(c + 1);
            ld_funct3 = 3'b010;
            ld_word   = 32'hA000_0000 + 32'(c + 1);
            step();
            if (c == 0 || c == 4) begin
                chk($sformatf("order_wen_c%0d", c), 32'(w_en), 32'd0);
            end else begin
                chk($sformatf("order_wen_c%0d", c), 32'(w_en), 32'd1);
                chk($sformatf("order_rd_c%0d", c), 32'(rd), 32'(c));
                chk($sformatf("order_data_c%0d", c), rdData, 32'hA000_0000 + 32'(c));
            end
        end
        idle_inputs();
        step();

        // Async reset with two loads buffered
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h77;
        ld_valid = 1'b1; ld_rd = 5'd4; ld_word = 32'h4444;
        step();
        ld_rd = 5'd5; ld_word = 32'h5555;
        step();
        ld_valid = 1'b0;
        chk("arst_pre_wen", 32'(w_en), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_wen",   32'(w_en), 32'd0);
        chk("arst_rd",    32'(rd), 32'd0);
        chk("arst_data",  rdData, 32'h0);
        chk("arst_ready", 32'(ld_ready), 32'd0);
        idle_inputs();
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            chk($sformatf("arst_stale_c%0d", c), 32'(w_en), 32'd0);
        end
        chk("arst_ready_after", 32'(ld_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
